// File: rtl/controle_placar.sv
// -----------------------------------------------------------------------------
// controle_placar
//
// Sequencing controller for the scoreboard digit-packing path. Point requests
// from team A and team B are arbitrated round-robin. Each granted request adds
// its points one at a time to that team's two-digit BCD score, which saturates
// at MAX_SCORE_TENS/9. The four score digits are time-multiplexed onto the
// packing path's nibble inputs: units in slot 0, tens in slot 1.
//
// Handshake: a requester raises req_x with pts_x stable and holds both until
// it sees ack_x high for one cycle. The requester drops req_x on the clock
// edge that ends the ack cycle. The controller returns to IDLE on that same
// edge, so a dropped request is never granted a second time.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   clear  in   1  synchronous score clear (aborts any transaction, no ack)
//   req_a  in   1  team A point request
//   pts_a  in   2  team A points (0..3)
//   req_b  in   1  team B point request
//   pts_b  in   2  team B points (0..3)
//   ack_a  out  1  one-cycle acknowledge to team A
//   ack_b  out  1  one-cycle acknowledge to team B
//   busy   out  1  high while the FSM is in ADD or ACK
//   n1     out  4  team A digit for the current scan slot
//   n2     out  4  team B digit for the current scan slot
//   slot   out  1  current scan slot (0 = units, 1 = tens)
// -----------------------------------------------------------------------------
module controle_placar #(
    parameter int SCAN_DIV       = 4,
    parameter int MAX_SCORE_TENS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       req_a,
    input  logic [1:0] pts_a,
    input  logic       req_b,
    input  logic [1:0] pts_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic       busy,
    output logic [3:0] n1,
    output logic [3:0] n2,
    output logic       slot
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // The counter is kept at least one bit wide so that SCAN_DIV = 1 still
    // elaborates. In that case the counter wraps on every cycle.
    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]       TENS_MAX = 4'(MAX_SCORE_TENS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_ptr;        // round-robin pointer: 0 = A first, 1 = B first
    logic             r_side;       // granted side: 0 = A, 1 = B
    logic [1:0]       r_remaining;  // points still to add in this transaction
    logic [3:0]       r_a_units;
    logic [3:0]       r_a_tens;
    logic [3:0]       r_b_units;
    logic [3:0]       r_b_tens;
    logic             r_ack_a;
    logic             r_ack_b;
    logic             r_busy;
    logic [CNT_W-1:0] r_scan_cnt;
    logic             r_slot;
    logic [3:0]       r_n1;
    logic [3:0]       r_n2;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic       w_req_any;
    logic       w_grant_b;
    logic [1:0] w_grant_pts;

    always_comb begin
        w_req_any   = req_a | req_b;
        // When both teams request, the side selected by the pointer wins.
        // When only one team requests, that team wins.
        w_grant_b   = req_b & (~req_a | r_ptr);
        w_grant_pts = w_grant_b ? pts_b : pts_a;
    end

    // ------------------------------------------------------------------
    // BCD increment of the granted team's score
    // ------------------------------------------------------------------
    logic [3:0] w_cur_units;
    logic [3:0] w_cur_tens;
    logic       w_sat;
    logic [3:0] w_inc_units;
    logic [3:0] w_inc_tens;

    always_comb begin
        w_cur_units = r_side ? r_b_units : r_a_units;
        w_cur_tens  = r_side ? r_b_tens  : r_a_tens;
        w_sat       = (w_cur_tens == TENS_MAX) && (w_cur_units == 4'd9);
        w_inc_units = w_cur_units;
        w_inc_tens  = w_cur_tens;
        if (!w_sat) begin
            if (w_cur_units == 4'd9) begin
                w_inc_units = 4'd0;
                w_inc_tens  = w_cur_tens + 4'd1;
            end else begin
                w_inc_units = w_cur_units + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan sequencing
    // ------------------------------------------------------------------
    logic w_scan_wrap;
    logic w_slot_nxt;

    always_comb begin
        w_scan_wrap = (r_scan_cnt == CNT_LAST);
        w_slot_nxt  = w_scan_wrap ? ~r_slot : r_slot;
    end

    // ------------------------------------------------------------------
    // Sequential logic: scan, FSM, scores and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_side      <= 1'b0;
            r_remaining <= 2'd0;
            r_a_units   <= 4'd0;
            r_a_tens    <= 4'd0;
            r_b_units   <= 4'd0;
            r_b_tens    <= 4'd0;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_busy      <= 1'b0;
            r_scan_cnt  <= '0;
            r_slot      <= 1'b0;
            r_n1        <= 4'd0;
            r_n2        <= 4'd0;
        end else begin
            // The scan keeps running through clear and through transactions.
            // The nibbles are refreshed on every cycle, so a new score is shown
            // within the slot that follows the increment.
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + CNT_W'(1);
            r_slot     <= w_slot_nxt;
            r_n1       <= w_slot_nxt ? r_a_tens : r_a_units;
            r_n2       <= w_slot_nxt ? r_b_tens : r_b_units;

            if (clear) begin
                // Abort any transaction silently. The pointer is not changed,
                // so a request that is still held is served again once clear
                // is released.
                r_a_units <= 4'd0;
                r_a_tens  <= 4'd0;
                r_b_units <= 4'd0;
                r_b_tens  <= 4'd0;
                r_state   <= IDLE;
                r_ack_a   <= 1'b0;
                r_ack_b   <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_ack_a <= 1'b0;
                        r_ack_b <= 1'b0;
                        if (w_req_any) begin
                            r_side      <= w_grant_b;
                            r_remaining <= w_grant_pts;
                            r_busy      <= 1'b1;
                            if (w_grant_pts == 2'd0) begin
                                // With zero points, go straight to the
                                // acknowledge in the next cycle.
                                r_state <= ACK;
                                r_ack_a <= ~w_grant_b;
                                r_ack_b <= w_grant_b;
                            end else begin
                                r_state <= ADD;
                            end
                        end else begin
                            r_busy <= 1'b0;
                        end
                    end

                    ADD: begin
                        // At saturation the increment has no effect, but the
                        // cycle is still counted against the remaining points.
                        if (r_side) begin
                            r_b_units <= w_inc_units;
                            r_b_tens  <= w_inc_tens;
                        end else begin
                            r_a_units <= w_inc_units;
                            r_a_tens  <= w_inc_tens;
                        end
                        r_remaining <= r_remaining - 2'd1;
                        if (r_remaining == 2'd1) begin
                            r_state <= ACK;
                            r_ack_a <= ~r_side;
                            r_ack_b <= r_side;
                        end
                    end

                    ACK: begin
                        r_ack_a <= 1'b0;
                        r_ack_b <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ptr   <= ~r_ptr;
                        r_state <= IDLE;
                    end

                    default: begin
                        r_ack_a <= 1'b0;
                        r_ack_b <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ack_a = r_ack_a;
    assign ack_b = r_ack_b;
    assign busy  = r_busy;
    assign n1    = r_n1;
    assign n2    = r_n2;
    assign slot  = r_slot;

endmodule

// File: tb/tb_controle_placar.sv
// -----------------------------------------------------------------------------
// tb_controle_placar
//
// Directed testbench for controle_placar. The DUT uses the default parameters
// SCAN_DIV = 4 and MAX_SCORE_TENS = 9. Inputs are driven and outputs are
// sampled on the falling edge of clk. Latency is counted in falling edges
// after the request is raised: a request with p points is acknowledged on
// the (p+1)-th falling edge.
// -----------------------------------------------------------------------------
module tb_controle_placar;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       req_a;
  logic [1:0] pts_a;
  logic       req_b;
  logic [1:0] pts_b;
  logic       ack_a;
  logic       ack_b;
  logic       busy;
  logic [3:0] n1;
  logic [3:0] n2;
  logic       slot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controle_placar #(
    .SCAN_DIV       (4),
    .MAX_SCORE_TENS (9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .req_a (req_a),
    .pts_a (pts_a),
    .req_b (req_b),
    .pts_b (pts_b),
    .ack_a (ack_a),
    .ack_b (ack_b),
    .busy  (busy),
    .n1    (n1),
    .n2    (n2),
    .slot  (slot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    req_a = 1'b0;
    pts_a = 2'd0;
    req_b = 1'b0;
    pts_b = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Raise one request, wait a bounded time for its ack, check the latency,
  // drop the request, then wait one idle cycle.
  task automatic serve(input bit side, input logic [1:0] p, input string tag);
    int  lat;
    bit  seen;
    logic other;
    if (side) begin
      req_b = 1'b1;
      pts_b = p;
    end else begin
      req_a = 1'b1;
      pts_a = p;
    end
    lat   = 0;
    seen  = 1'b0;
    other = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (side ? ack_b : ack_a) begin
        seen  = 1'b1;
        other = side ? ack_a : ack_b;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(p) + 32'd1);
    chk({tag, "_other_ack"}, {31'd0, other}, 32'd0);
    if (side) req_b = 1'b0;
    else      req_a = 1'b0;
    @(negedge clk);
  endtask

  // Read both displayed scores as {tens, units} through the scan.
  task automatic read_scores(output logic [7:0] sa, output logic [7:0] sb);
    int n;
    sa = 8'd0;
    sb = 8'd0;
    repeat (2) @(negedge clk);
    n = 0;
    while (slot !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scan_reach_units", {31'd0, slot}, 32'd0);
    sa[3:0] = n1;
    sb[3:0] = n2;
    n = 0;
    while (slot !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scan_reach_tens", {31'd0, slot}, 32'd1);
    sa[7:4] = n1;
    sb[7:4] = n2;
  endtask

  initial begin
    logic [7:0] sa;
    logic [7:0] sb;
    logic [3:0] order;
    int         k;
    int         na;
    int         nb;
    int         n;
    bit         seen;

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_ack_a", {31'd0, ack_a}, 32'd0);
    chk("rst_ack_b", {31'd0, ack_b}, 32'd0);
    chk("rst_n1",    {28'd0, n1},    32'd0);
    chk("rst_n2",    {28'd0, n2},    32'd0);
    chk("rst_slot",  {31'd0, slot},  32'd0);

    // ---------------- scan period: slot toggles on the 4th edge ----------------
    repeat (3) @(negedge clk);
    chk("scan_slot_before_wrap", {31'd0, slot}, 32'd0);
    @(negedge clk);
    chk("scan_slot_after_wrap", {31'd0, slot}, 32'd1);

    // ---------------- test 1: A with 3 points, cycle by cycle ----------------
    req_a = 1'b1;
    pts_a = 2'd3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("t1_busy_c%0d", c), {31'd0, busy}, 32'd1);
      chk($sformatf("t1_ack_a_c%0d", c), {31'd0, ack_a}, (c == 4) ? 32'd1 : 32'd0);
    end
    req_a = 1'b0;
    @(negedge clk);
    chk("t1_ack_a_after", {31'd0, ack_a}, 32'd0);
    chk("t1_busy_after",  {31'd0, busy},  32'd0);
    read_scores(sa, sb);
    chk("t1_score_a", {24'd0, sa}, 32'h03);
    chk("t1_score_b", {24'd0, sb}, 32'h00);

    // ---------------- test 2: saturation at 99 ----------------
    do_reset();
    for (int i = 0; i < 32; i++) serve(1'b0, 2'd3, "t2_fill");
    serve(1'b0, 2'd2, "t2_fill_last");
    read_scores(sa, sb);
    chk("t2_score_98", {24'd0, sa}, 32'h98);
    serve(1'b0, 2'd3, "t2_sat");
    read_scores(sa, sb);
    chk("t2_score_a_sat", {24'd0, sa}, 32'h99);
    chk("t2_score_b", {24'd0, sb}, 32'h00);

    // ---------------- test 3: round-robin fairness ----------------
    do_reset();
    req_a = 1'b1;
    pts_a = 2'd1;
    req_b = 1'b1;
    pts_b = 2'd1;
    order = 4'd0;
    k = 0;
    na = 0;
    nb = 0;
    n = 0;
    while (k < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (ack_a) begin
        order[k] = 1'b0;
        k++;
        na++;
        req_a = 1'b0;
      end else if (ack_b) begin
        order[k] = 1'b1;
        k++;
        nb++;
        req_b = 1'b0;
      end else begin
        if (!req_a && na < 2) req_a = 1'b1;
        if (!req_b && nb < 2) req_b = 1'b1;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    chk("t3_ack_count", 32'(k), 32'd4);
    chk("t3_order", {28'd0, order}, 32'b1010);
    read_scores(sa, sb);
    chk("t3_score_a", {24'd0, sa}, 32'h02);
    chk("t3_score_b", {24'd0, sb}, 32'h02);

    // ---------------- test 4: B units carry 09 -> 11 ----------------
    do_reset();
    for (int i = 0; i < 3; i++) serve(1'b1, 2'd3, "t4_fill");
    read_scores(sa, sb);
    chk("t4_score_b_09", {24'd0, sb}, 32'h09);
    serve(1'b1, 2'd2, "t4_carry");
    read_scores(sa, sb);
    chk("t4_n2_tens", {28'd0, n2}, 32'd1);
    chk("t4_score_b_11", {24'd0, sb}, 32'h11);
    chk("t4_score_a", {24'd0, sa}, 32'h00);

    // ---------------- test 5: zero points, pointer toggle ----------------
    // The pointer is A after four acks. An A request with zero points moves it
    // to B, and a B request with zero points moves it back to A.
    serve(1'b0, 2'd0, "t5_a_zero");
    serve(1'b1, 2'd0, "t5_b_zero");
    read_scores(sa, sb);
    chk("t5_score_a", {24'd0, sa}, 32'h00);
    chk("t5_score_b", {24'd0, sb}, 32'h11);
    req_a = 1'b1;
    pts_a = 2'd0;
    req_b = 1'b1;
    pts_b = 2'd0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (ack_a || ack_b) begin
        seen = 1'b1;
        chk("t5_first_ack_a", {31'd0, ack_a}, 32'd1);
        chk("t5_first_ack_b", {31'd0, ack_b}, 32'd0);
      end
    end
    chk("t5_first_seen", {31'd0, seen}, 32'd1);
    req_a = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (ack_b) seen = 1'b1;
    end
    chk("t5_second_b_seen", {31'd0, seen}, 32'd1);
    req_b = 1'b0;
    @(negedge clk);

    // ---------------- test 6a: clear mid-ADD ----------------
    do_reset();
    serve(1'b0, 2'd3, "t6_fill");
    serve(1'b0, 2'd2, "t6_fill");
    read_scores(sa, sb);
    chk("t6_score_05", {24'd0, sa}, 32'h05);
    req_a = 1'b1;
    pts_a = 2'd3;
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy_mid_add", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    chk("t6_clear_ack_a", {31'd0, ack_a}, 32'd0);
    chk("t6_clear_busy",  {31'd0, busy},  32'd0);
    @(negedge clk);
    chk("t6_clear_ack_a2", {31'd0, ack_a}, 32'd0);
    chk("t6_clear_n1", {28'd0, n1}, 32'd0);
    chk("t6_clear_n2", {28'd0, n2}, 32'd0);
    clear = 1'b0;
    serve(1'b0, 2'd3, "t6_reserve");
    read_scores(sa, sb);
    chk("t6_score_a_03", {24'd0, sa}, 32'h03);

    // ---------------- test 6b: reset mid-ADD ----------------
    req_a = 1'b1;
    pts_a = 2'd3;
    @(negedge clk);
    @(negedge clk);
    chk("t6b_busy_mid_add", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6b_busy",  {31'd0, busy},  32'd0);
    chk("t6b_ack_a", {31'd0, ack_a}, 32'd0);
    chk("t6b_n1",    {28'd0, n1},    32'd0);
    chk("t6b_n2",    {28'd0, n2},    32'd0);
    chk("t6b_slot",  {31'd0, slot},  32'd0);
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack_a || ack_b) seen = 1'b1;
    end
    chk("t6b_no_ack_after_reset", {31'd0, seen}, 32'd0);
    read_scores(sa, sb);
    chk("t6b_score_a", {24'd0, sa}, 32'h00);
    chk("t6b_score_b", {24'd0, sb}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
